// File: rtl/mcpu_alu_seq.sv
// Registered, handshaked ALU: single-cycle logic/add/sub/shift ops plus a
// multi-cycle shift-add multiplier, with one valid/ready-guarded result register.
module mcpu_alu_seq #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned CMD_SIZE  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CMD_SIZE-1:0]  opcode,
  input  logic [WORD_SIZE-1:0] r1,
  input  logic [WORD_SIZE-1:0] r2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out,
  output logic                 overflow,
  output logic                 zero
);

  localparam int unsigned SH_W  = $clog2(WORD_SIZE);
  localparam int unsigned CNT_W = SH_W;
  localparam int unsigned ACC_W = 2 * WORD_SIZE;

  localparam logic [CMD_SIZE-1:0] OP_AND = CMD_SIZE'(0);
  localparam logic [CMD_SIZE-1:0] OP_OR  = CMD_SIZE'(1);
  localparam logic [CMD_SIZE-1:0] OP_XOR = CMD_SIZE'(2);
  localparam logic [CMD_SIZE-1:0] OP_ADD = CMD_SIZE'(3);
  localparam logic [CMD_SIZE-1:0] OP_SUB = CMD_SIZE'(4);
  localparam logic [CMD_SIZE-1:0] OP_SHL = CMD_SIZE'(5);
  localparam logic [CMD_SIZE-1:0] OP_SHR = CMD_SIZE'(6);
  localparam logic [CMD_SIZE-1:0] OP_MUL = CMD_SIZE'(7);

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] out_q, out_d;
  logic                 ovf_q, ovf_d;
  logic                 zero_q, zero_d;
  logic                 valid_q, valid_d;
  logic [ACC_W-1:0]     mcand_q, mcand_d;
  logic [WORD_SIZE-1:0] mplier_q, mplier_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 accept;
  logic                 consume;
  logic [WORD_SIZE:0]   sum;
  logic [ACC_W-1:0]     shl_wide;
  logic [ACC_W-1:0]     acc_step;
  logic [WORD_SIZE-1:0] alu_res;
  logic                 alu_ovf;

  assign in_ready  = (state_q == IDLE) && (!valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign consume   = valid_q && out_ready;
  assign out_valid = valid_q;
  assign out       = out_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

  // Widened helpers so carry and shifted-out bits stay visible.
  assign sum      = {1'b0, r1} + {1'b0, r2};
  assign shl_wide = ACC_W'(r1) << r2[SH_W-1:0];
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Single-cycle operations.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (opcode)
      OP_AND: alu_res = r1 & r2;
      OP_OR:  alu_res = r1 | r2;
      OP_XOR: alu_res = r1 ^ r2;
      OP_ADD: begin
        alu_res = sum[WORD_SIZE-1:0];
        alu_ovf = sum[WORD_SIZE];
      end
      OP_SUB: begin
        alu_res = r1 - r2;
        alu_ovf = (r1 < r2);
      end
      OP_SHL: begin
        alu_res = shl_wide[WORD_SIZE-1:0];
        alu_ovf = |shl_wide[ACC_W-1:WORD_SIZE];
      end
      OP_SHR: alu_res = r1 >> r2[SH_W-1:0];
      default: ;
    endcase
  end

  // Next-state and result-register logic.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    valid_d  = valid_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    if (consume) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (opcode == OP_MUL) begin
            mcand_d  = ACC_W'(r1);
            mplier_d = r2;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end else begin
            out_d   = alu_res;
            ovf_d   = alu_ovf;
            zero_d  = (alu_res == '0);
            valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        // One multiplier bit per cycle, LSB first.
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WORD_SIZE - 1)) begin
          out_d   = acc_step[WORD_SIZE-1:0];
          ovf_d   = |acc_step[ACC_W-1:WORD_SIZE];
          zero_d  = (acc_step[WORD_SIZE-1:0] == '0);
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      out_q    <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mcpu_alu_seq.sv
// Scoreboard bench for mcpu_alu_seq: directed cases plus randomized operations
// checked against an arithmetic reference model.
module tb_mcpu_alu_seq;

  localparam int unsigned W   = 8;
  localparam int unsigned MOD = 256;

  typedef struct {
    int unsigned res;
    bit          ovf;
    bit          zf;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   opcode;
  logic [W-1:0] r1, r2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         overflow;
  logic         zero;

  int   checks   = 0;
  int   failures = 0;
  exp_t sbq[$];
  exp_t mon_e;
  bit   rand_rdy = 1'b0;

  mcpu_alu_seq #(.WORD_SIZE(W), .CMD_SIZE(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .r1(r1), .r2(r2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(int unsigned res, bit ovf, bit zf);
    exp_t e;
    e.res = res; e.ovf = ovf; e.zf = zf;
    return e;
  endfunction

  // Reference behaviour from the opcode table, using plain integer arithmetic.
  function automatic exp_t model(int unsigned op, int unsigned a, int unsigned b);
    int unsigned r, sh;
    bit v;
    r = 0; v = 1'b0; sh = b % W;
    case (op)
      0: r = a & b;
      1: r = a | b;
      2: r = a ^ b;
      3: begin r = a + b; v = (r >= MOD); end
      4: begin r = a + MOD - b; v = (a < b); end
      5: begin r = a * (1 << sh); v = (r >= MOD); end
      6: r = a / (1 << sh);
      default: begin r = a * b; v = (r >= MOD); end
    endcase
    r = r % MOD;
    return mk(r, v, r == 0);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present an op, wait for acceptance, record the expected result.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input exp_t e, output int waits);
    opcode = op; r1 = a; r2 = b; in_valid = 1'b1; waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL issue_timeout: op %0d not accepted after %0d cycles", op, waits);
      in_valid = 1'b0;
      return;
    end
    sbq.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    r1 = $urandom; r2 = $urandom;
  endtask

  // Monitor: every consumed result is compared with the scoreboard head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_result: got out=%0d with nothing expected", out);
      end else begin
        mon_e = sbq.pop_front();
        chk("out", 32'(out), mon_e.res);
        chk("overflow", 32'(overflow), 32'(mon_e.ovf));
        chk("zero", 32'(zero), 32'(mon_e.zf));
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #2;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, lat, busy;
    bit rose;
    exp_t e;
    reset = 1'b1; in_valid = 1'b0; opcode = '0; r1 = '0; r2 = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out", 32'(out), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_zero", 32'(zero), 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    issue(3'd0, 8'd4, 8'd5, mk(4, 0, 0), w);
    chk("and_latency", 32'(out_valid), 1);
    issue(3'd2, 8'd5, 8'd5, mk(0, 0, 1), w);
    issue(3'd3, 8'd200, 8'd100, mk(44, 1, 0), w);
    issue(3'd4, 8'd3, 8'd5, mk(254, 1, 0), w);
    issue(3'd5, 8'd3, 8'd7, mk(128, 1, 0), w);
    issue(3'd6, 8'd128, 8'd7, mk(1, 0, 0), w);

    // MUL latency and busy window
    issue(3'd7, 8'd15, 8'd17, mk(255, 0, 0), w);
    lat = 0; busy = 0;
    while (!out_valid && lat < 30) begin
      if (!in_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
    chk("mul_latency", lat, 8);
    chk("mul_busy_cycles", busy, 8);
    issue(3'd7, 8'd16, 8'd16, mk(0, 1, 1), w);
    repeat (10) begin @(posedge clk); #1; end

    // Backpressure: ADD held, pending OR must wait
    out_ready = 1'b0;
    issue(3'd3, 8'd1, 8'd2, mk(3, 0, 0), w);
    opcode = 3'd1; r1 = 8'd12; r2 = 8'd3; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_hold", 32'(out), 3);
      chk("bp_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue(3'd1, 8'd12, 8'd3, mk(15, 0, 0), w);
    chk("bp_release_same_cycle", w, 0);

    // Streaming
    issue(3'd0, 8'hF0, 8'h3C, mk(8'h30, 0, 0), w);
    chk("stream_and_wait", w, 0);
    issue(3'd1, 8'hF0, 8'h0C, mk(8'hFC, 0, 0), w);
    chk("stream_or_wait", w, 0);
    issue(3'd2, 8'hAA, 8'hAA, mk(0, 0, 1), w);
    chk("stream_xor_wait", w, 0);
    repeat (2) begin @(posedge clk); #1; end

    // Reset in the middle of a MUL
    issue(3'd7, 8'd255, 8'd255, mk(1, 1, 0), w);
    rose = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (out_valid) rose = 1'b1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sbq.delete();
    chk("mid_mul_rst_in_ready", 32'(in_ready), 1);
    chk("mid_mul_rst_out", 32'(out), 0);
    repeat (10) begin if (out_valid) rose = 1'b1; @(posedge clk); #1; end
    chk("mid_mul_no_result", 32'(rose), 0);
    issue(3'd3, 8'd1, 8'd1, mk(2, 0, 0), w);
    chk("post_rst_add_latency", 32'(out_valid), 1);
    @(posedge clk); #1;

    // Randomized operations with random consumer stalls
    rand_rdy = 1'b1;
    for (int n = 0; n < 150; n++) begin
      logic [2:0] op;
      logic [W-1:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = W'($urandom);
      b  = W'($urandom);
      e  = model(32'(op), 32'(a), 32'(b));
      issue(op, a, b, e, w);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && sbq.size() != 0; k++) begin @(posedge clk); #1; end
    chk("drain_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcpu_alu_seq.md
# mcpu_alu_seq

Registered, handshaked successor to the microCPU combinational ALU. It is parametrised in word width and extends the operation set from four to eight. SUB and the shifts complete in one cycle; MUL is a multi-cycle shift-add. Results go into a single output register with valid/ready flow control, together with overflow and zero flags, so the CPU datapath or a bench can stall the ALU without losing a result.

## Interface
Parameters:
- WORD_SIZE, 8, operand and result width (≥ 2, power of two)
- CMD_SIZE, 3, opcode width (fixed at 3; eight operations)

Ports:
- clk  in  1  single clock; everything updates on the rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  opcode and operands presented
- in_ready  out  1  block can accept an operation this cycle
- opcode  in  CMD_SIZE  operation select
- r1  in  WORD_SIZE  operand A
- r2  in  WORD_SIZE  operand B
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  consumer takes the result this cycle
- out  out  WORD_SIZE  result
- overflow  out  1  overflow flag for the held result
- zero  out  1  1 when out == 0

## Operation
Opcode map and flag rules:
- 000 AND: r1&r2; overflow 0.
- 001 OR: r1|r2; overflow 0.
- 010 XOR: r1^r2; overflow 0.
- 011 ADD: low WORD_SIZE bits of r1+r2; overflow = carry out.
- 100 SUB: r1−r2 modulo 2^WORD_SIZE; overflow = borrow (r1<r2).
- 101 SHL: r1 << r2[$clog2(WORD_SIZE)-1:0]; overflow = 1 if any 1-bit is shifted out.
- 110 SHR: logical r1 >> same amount; overflow 0.
- 111 MUL: unsigned; low WORD_SIZE bits of the product; overflow = 1 if the upper WORD_SIZE bits are nonzero.

Handshake and state machine:
- An operation is accepted when in_valid && in_ready at a rising edge.
- A result is consumed when out_valid && out_ready at a rising edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational and never depends on in_valid.
- State IDLE, accepting a non-MUL operation: the result and flags are registered at the accepting edge and out_valid is set. State stays IDLE.
- State IDLE, accepting MUL: the multiplicand, multiplier and a 2·WORD_SIZE accumulator are loaded, the step counter is cleared, and state goes to MUL.
- State MUL: one multiplier bit is processed per cycle, LSB first; the counter increments. On the WORD_SIZE-th step, out, overflow and zero are written, out_valid is set, and state returns to IDLE.
- While state is MUL, in_ready = 0.
- Simultaneous consume and accept in IDLE is legal: the new result replaces the old one in the same edge and out_valid stays 1.
- Consume with no accept: out_valid → 0. out, overflow and zero keep their last values.
- Operands are sampled only at accept. Input changes afterwards have no effect.

## Timing
- Reset values: out_valid 0, out 0, overflow 0, zero 0, state IDLE, counter 0. in_ready is 1 in the first cycle after reset.
- Reset asserted mid-MUL aborts the operation. No result is produced, and out_valid stays 0.
- Reset has priority over accept and consume in the same cycle.
- Latency for non-MUL: accept at edge E gives out_valid = 1 after edge E.
- Latency for MUL: accept at edge E gives out_valid = 1 after edge E+WORD_SIZE. in_ready is 0 for exactly WORD_SIZE cycles (E+1 … E+WORD_SIZE) while state is MUL; it is 1 again from the cycle after edge E+WORD_SIZE, given that the output slot is empty or being consumed.
- Throughput: one non-MUL operation per cycle when out_ready is held at 1.
- Backpressure: while out_valid && !out_ready, the outputs are stable and in_ready = 0.

## Test plan
WORD_SIZE = 8 throughout.
- Reset: after reset, out_valid=0, out=0, overflow=0, zero=0, in_ready=1. Run AND 4,5 → out 4, ovf 0, zero 0, one cycle later. Run XOR 5,5 → out 0, zero 1.
- Arithmetic: ADD 200,100 → out 44, ovf 1. SUB 3,5 → out 254, ovf 1. SHL 3 by 7 → out 128, ovf 1. SHR 128 by 7 → out 1, ovf 0.
- Multi-cycle: MUL 15,17 → out 255, ovf 0, out_valid exactly 8 cycles after accept, in_ready 0 for those 8 cycles. MUL 16,16 → out 0, ovf 1, zero 1.
- Backpressure and streaming: hold out_ready=0 after ADD 1,2 → out holds 3 and in_ready=0 for 5 cycles, and a pending OR is not accepted. Release out_ready → OR accepted in the same cycle the 3 is consumed. Back-to-back AND/OR/XOR with out_ready=1 → one result per cycle, in order.
- Reset mid-MUL: MUL 255,255 accepted, reset asserted 4 cycles later → out_valid never rises, in_ready=1 after reset, and the next ADD 1,1 → out 2 with normal latency.
